// File: rtl/uart_slot_pkg.sv
// Shared constants for the UART slot controller:
// slot word addresses, status bit positions and FSM encoding.
package uart_slot_pkg;

    localparam logic [1:0] ADDR_DVSR = 2'd1;
    localparam logic [1:0] ADDR_TX   = 2'd2;
    localparam logic [1:0] ADDR_RX   = 2'd3;

    localparam int TX_FULL_BIT  = 9;
    localparam int RX_EMPTY_BIT = 8;

    typedef enum logic {
        CFG = 1'b0,
        RUN = 1'b1
    } state_t;

endpackage

// File: rtl/uart_slot_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first request at or above ptr,
// wrapping; reports one-hot grant, index and whether any was found.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx,
    output logic             any
);

    int k;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            k = (int'(ptr) + i) % N_REQ;
            if (!any && req[k]) begin
                any      = 1'b1;
                grant[k] = 1'b1;
                idx      = k[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_slot_ctrl.sv
// Master-side UART slot controller: divisor programming, packet-locked
// round-robin TX sharing and RX drain, one slot access per clock.
module uart_slot_ctrl
    import uart_slot_pkg::*;
#(
    parameter int          N_REQ        = 4,
    parameter logic [10:0] DVSR_DEFAULT = 11'd650
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [10:0]        cfg_dvsr,
    input  logic               cfg_load,
    output logic               cfg_done,
    input  logic [N_REQ-1:0]   tx_valid,
    input  logic [8*N_REQ-1:0] tx_data,
    input  logic [N_REQ-1:0]   tx_last,
    output logic [N_REQ-1:0]   tx_ready,
    output logic [2:0]         grant_id,
    output logic               rx_valid,
    output logic [7:0]         rx_data,
    input  logic               rx_ready,
    output logic               slot_cs,
    output logic               slot_write,
    output logic               slot_read,
    output logic [1:0]         slot_addr,
    output logic [31:0]        slot_wr_data,
    input  logic [31:0]        slot_rd_data
);

    localparam int IW = $clog2(N_REQ);

    state_t            state_q, state_d;
    logic [10:0]       dvsr_q;
    logic              lock;
    logic [IW-1:0]     rr_ptr;
    logic              rx_pri;

    logic [N_REQ-1:0]  arb_grant;
    logic [IW-1:0]     arb_idx;
    logic              arb_any;
    logic [IW-1:0]     sel;
    logic [N_REQ-1:0]  sel_onehot;
    logic              sel_valid;
    logic              tx_full, rx_empty;
    logic              run, cfg_wr;
    logic              rx_want, tx_want, do_rx, do_tx;
    logic              unused_rd;

    assign tx_full   = slot_rd_data[TX_FULL_BIT];
    assign rx_empty  = slot_rd_data[RX_EMPTY_BIT];
    assign unused_rd = ^slot_rd_data[31:10];
    assign slot_read = 1'b0;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req   (tx_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // A locked packet keeps its owner even while the owner idles.
    always_comb begin
        sel_onehot = '0;
        sel_onehot[grant_id[IW-1:0]] = 1'b1;
        if (!lock)
            sel_onehot = arb_grant;
    end

    assign sel       = lock ? grant_id[IW-1:0] : arb_idx;
    assign sel_valid = lock ? tx_valid[grant_id[IW-1:0]] : arb_any;

    assign run     = reset && (state_q == RUN) && !cfg_load;
    assign cfg_wr  = reset && (state_q == CFG) && !cfg_load;
    assign rx_want = run && !rx_empty && (!rx_valid || rx_ready);
    assign tx_want = run && !tx_full && sel_valid;
    assign do_rx   = rx_want && (!tx_want || rx_pri);
    assign do_tx   = tx_want && !do_rx;

    always_ff @(posedge clk) begin
        if (!reset)
            state_q <= CFG;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cfg_load)
            state_d = CFG;
        else if (state_q == CFG)
            state_d = RUN;
    end

    always_comb begin
        slot_cs      = 1'b0;
        slot_write   = 1'b0;
        slot_addr    = '0;
        slot_wr_data = '0;
        tx_ready     = '0;
        if (cfg_wr) begin
            slot_cs      = 1'b1;
            slot_write   = 1'b1;
            slot_addr    = ADDR_DVSR;
            slot_wr_data = {21'b0, dvsr_q};
        end else if (do_rx) begin
            slot_cs    = 1'b1;
            slot_write = 1'b1;
            slot_addr  = ADDR_RX;
        end else if (do_tx) begin
            slot_cs      = 1'b1;
            slot_write   = 1'b1;
            slot_addr    = ADDR_TX;
            slot_wr_data = {24'b0, tx_data[8*sel +: 8]};
            tx_ready     = sel_onehot;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dvsr_q   <= DVSR_DEFAULT;
            cfg_done <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            grant_id <= '0;
            lock     <= 1'b0;
            rr_ptr   <= '0;
            rx_pri   <= 1'b0;
        end else begin
            if (cfg_load) begin
                dvsr_q   <= cfg_dvsr;
                cfg_done <= 1'b0;
            end else if (cfg_wr) begin
                cfg_done <= 1'b1;
            end
            if (do_rx) begin
                rx_data  <= slot_rd_data[7:0];
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (rx_want && tx_want)
                rx_pri <= !rx_pri;
            if (do_tx) begin
                grant_id <= 3'(sel);
                if (tx_last[sel]) begin
                    lock   <= 1'b0;
                    rr_ptr <= (sel == IW'(N_REQ - 1)) ? '0 : sel + 1'b1;
                end else begin
                    lock <= 1'b1;
                end
            end
        end
    end

endmodule
